serializador_ascii: RTL and testbench

Downstream stage of the number concatenator: takes a finished binary integer result, converts it to decimal ASCII and streams it byte by byte into the UART transmitter, followed by a terminator byte. It sits between the concatenator/arithmetic path and the UART TX. It owns the TX byte handshake so upstream logic only issues one start pulse per number.

---
 rtl/serializador_ascii_if.sv | 12 +
 rtl/serializador_ascii.sv | 109 ++++++++++
 tb/tb_serializador_ascii.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serializador_ascii_if.sv
// serializador_ascii_if: value request and UART TX byte handshake between upstream, serializador_ascii and the TX.
interface serializador_ascii_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] valor;
  logic valor_valid;
  logic busy;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_done;
  logic done;
  modport master (output valor, valor_valid, tx_done, input busy, tx_data, tx_start, done);
  modport slave (input valor, valor_valid, tx_done, output busy, tx_data, tx_start, done);
endinterface

// File: rtl/serializador_ascii.sv
// serializador_ascii: binary value -> decimal ASCII byte stream for the UART TX, then TERMINATOR.
// Define SERIALIZADOR_SIGNO_EN to treat valor as two's complement and prefix negatives with '-'.
module serializador_ascii #(
  parameter int WIDTH = 32,
  parameter int NDIG = 10,
  parameter logic [7:0] TERMINATOR = 8'h0A
) (
  input logic clk,
  input logic reset,
  serializador_ascii_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(NDIG);
  localparam logic [2:0] IDLE = 3'd0, CONV = 3'd1, LOAD = 3'd2, DIGIT = 3'd4, TERM = 3'd5, FIN = 3'd6;
`ifdef SERIALIZADOR_SIGNO_EN
  localparam logic [2:0] SIGN = 3'd3;
  logic neg;
`endif
  logic [2:0] state;
  logic [WIDTH-1:0] mag;
  logic [4*NDIG-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, msd, nidx;
  logic [3:0] first, cur, nxt;
  always_comb begin
    adj = bcd;
    msd = '0;
    for (int i = 0; i < NDIG; i++) begin
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
      if (bcd[4*i+:4] != 4'd0) msd = IW'(i);
    end
    nidx = idx - IW'(1);
    first = bcd[4*msd+:4];
    cur = bcd[4*idx+:4];
    nxt = bcd[4*nidx+:4];
  end
  // A send state is in its wait phase whenever tx_start is low, so tx_done in the tx_start cycle is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.done <= 1'b0;
      bus.tx_data <= 8'h00;
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
`ifdef SERIALIZADOR_SIGNO_EN
      neg <= 1'b0;
`endif
    end else begin
      bus.tx_start <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.valor_valid) begin
          bus.busy <= 1'b1;
          bcd <= '0;
          cnt <= CW'(WIDTH - 1);
          state <= CONV;
`ifdef SERIALIZADOR_SIGNO_EN
          neg <= bus.valor[WIDTH-1];
          mag <= bus.valor[WIDTH-1] ? -bus.valor : bus.valor;
`else
          mag <= bus.valor;
`endif
        end
        CONV: begin
          {bcd, mag} <= {adj, mag} << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= LOAD;
        end
        LOAD: begin
          idx <= msd;
          bus.tx_start <= 1'b1;
`ifdef SERIALIZADOR_SIGNO_EN
          state <= neg ? SIGN : DIGIT;
          bus.tx_data <= neg ? 8'h2D : {4'h3, first};
`else
          state <= DIGIT;
          bus.tx_data <= {4'h3, first};
`endif
        end
`ifdef SERIALIZADOR_SIGNO_EN
        SIGN: if (!bus.tx_start && bus.tx_done) begin
          bus.tx_start <= 1'b1;
          bus.tx_data <= {4'h3, cur};
          state <= DIGIT;
        end
`endif
        DIGIT: if (!bus.tx_start && bus.tx_done) begin
          bus.tx_start <= 1'b1;
          bus.tx_data <= idx == '0 ? TERMINATOR : {4'h3, nxt};
          state <= idx == '0 ? TERM : DIGIT;
          idx <= nidx;
        end
        TERM: if (!bus.tx_start && bus.tx_done) begin
          bus.done <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serializador_ascii.sv
// tb_serializador_ascii: directed and random numbers checked against a string-formatting reference model.
module tb_serializador_ascii;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  serializador_ascii_if #(.WIDTH(32)) bus ();
  serializador_ascii dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic string model(input logic [31:0] v);
`ifdef SERIALIZADOR_SIGNO_EN
    if (v[31]) return $sformatf("-%0d", 32'(-v));
`endif
    return $sformatf("%0d", v);
  endfunction
  // Sends one number; stop>=0 returns while byte 'stop' has just been started.
  task automatic run(input logic [31:0] v, input int stop, input bit glitch, input bit early);
    string s;
    int n, nb, d;
    logic [7:0] e;
    bit ok;
    s = model(v);
    nb = s.len() + 1;
    bus.valor = v;
    bus.valor_valid = 1'b1;
    tick();
    bus.valor_valid = 1'b0;
    chk("busy_accept", bus.busy, 1);
    n = 1;
    while (!bus.tx_start && n < 100) begin
      tick();
      n++;
    end
    chk("first_start_cycle", n, 34);
    for (int i = 0; i < nb; i++) begin
      e = i < s.len() ? s[i] : 8'h0A;
      chk($sformatf("byte%0d_of_%s", i, s), bus.tx_data, e);
      if (i == stop) return;
      if (early && i == 0) bus.tx_done = 1'b1;
      ok = 1'b1;
      d = $urandom_range(1, 20);
      for (int k = 0; k < d; k++) begin
        tick();
        bus.tx_done = 1'b0;
        bus.valor_valid = glitch && i == 1 && k == 0;
        bus.valor = glitch ? $urandom : v;
        ok &= bus.tx_start === 1'b0 && bus.tx_data === e && bus.busy === 1'b1 && bus.done === 1'b0;
      end
      chk("hold_while_waiting", ok, 1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      bus.valor_valid = 1'b0;
      if (i < nb - 1) chk("next_start", bus.tx_start, 1);
      else begin
        chk("done_busy", {bus.done, bus.busy}, 2'b11);
        tick();
        chk("idle_after_done", {bus.done, bus.busy, bus.tx_start}, 3'b000);
      end
    end
  endtask
  task automatic quiet(input string tag, input int cycles);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      tick();
      ok &= bus.tx_start === 1'b0 && bus.done === 1'b0 && bus.busy === 1'b0;
    end
    chk(tag, ok, 1);
  endtask
  initial begin
    logic [31:0] v;
    bus.valor = '0;
    bus.valor_valid = 1'b0;
    bus.tx_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    reset = 1'b0;
    tick();
    run(32'd0, -1, 1'b0, 1'b0);
    run(32'd1234, -1, 1'b0, 1'b1);
    run(-32'sd7, -1, 1'b0, 1'b0);
    run(32'h80000000, -1, 1'b0, 1'b0);
    run(32'hFFFFFFFF, -1, 1'b1, 1'b0);
    quiet("no_queued_request", 40);
    run(32'd987, 2, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outputs", {bus.tx_start, bus.busy, bus.done}, 3'b000);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    quiet("stray_tx_done", 5);
    run(32'd5, -1, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      v = $urandom >> $urandom_range(0, 31);
      run(v, -1, 1'b0, r[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
